// File: rtl/pic16_alu_pkg.sv
// Shared definitions for the PIC16 ALU: operation codes, bit-op groups
// and small helpers used by the datapath.
package pic16_alu_pkg;

    localparam int CB_W   = 5;
    localparam int DATA_W = 8;

    // Byte operations (CB[4] = 0)
    localparam logic [CB_W-1:0] OP_MOVW   = 5'b00000;
    localparam logic [CB_W-1:0] OP_CLR    = 5'b00001;
    localparam logic [CB_W-1:0] OP_SUBWF  = 5'b00010;
    localparam logic [CB_W-1:0] OP_DECF   = 5'b00011;
    localparam logic [CB_W-1:0] OP_IORWF  = 5'b00100;
    localparam logic [CB_W-1:0] OP_ANDWF  = 5'b00101;
    localparam logic [CB_W-1:0] OP_XORWF  = 5'b00110;
    localparam logic [CB_W-1:0] OP_ADDWF  = 5'b00111;
    localparam logic [CB_W-1:0] OP_MOVF   = 5'b01000;
    localparam logic [CB_W-1:0] OP_COMF   = 5'b01001;
    localparam logic [CB_W-1:0] OP_INCF   = 5'b01010;
    localparam logic [CB_W-1:0] OP_DECFSZ = 5'b01011;
    localparam logic [CB_W-1:0] OP_RRF    = 5'b01100;
    localparam logic [CB_W-1:0] OP_RLF    = 5'b01101;
    localparam logic [CB_W-1:0] OP_SWAPF  = 5'b01110;
    localparam logic [CB_W-1:0] OP_INCFSZ = 5'b01111;

    // Literal operations reuse byte codes; FI carries the literal
    localparam logic [CB_W-1:0] IPSF = 5'b01000;
    localparam logic [CB_W-1:0] IOR  = 5'b00100;
    localparam logic [CB_W-1:0] IAND = 5'b00101;
    localparam logic [CB_W-1:0] IXOR = 5'b00110;
    localparam logic [CB_W-1:0] ISUB = 5'b00010;
    localparam logic [CB_W-1:0] IADD = 5'b00111;

    // Bit-operation groups (CB[3:2] when CB[4] = 1)
    localparam logic [1:0] BG_BCF   = 2'b00;
    localparam logic [1:0] BG_BSF   = 2'b01;
    localparam logic [1:0] BG_BTFSC = 2'b10;
    localparam logic [1:0] BG_BTFSS = 2'b11;

    // Zero detect shared by all flag paths
    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/pic16_alu_if.sv
// Operand/result bundle between the PIC16 core sequencer and its ALU.
interface pic16_alu_if
    import pic16_alu_pkg::*;
();
    logic [CB_W-1:0]   CB;
    logic              WE;
    logic [2:0]        B;
    logic [DATA_W-1:0] FI;
    logic              CI;
    logic [DATA_W-1:0] FO;
    logic              CO;
    logic              DC;
    logic              Z;

    modport master (
        output CB, WE, B, FI, CI,
        input  FO, CO, DC, Z
    );

    modport slave (
        input  CB, WE, B, FI, CI,
        output FO, CO, DC, Z
    );
endinterface

// File: rtl/pic16_alu.sv
// PIC16 ALU: zero-latency result/flag datapath plus the W working register.
module pic16_alu
    import pic16_alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    pic16_alu_if.slave  bus
);

    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_d;

    logic [DATA_W-1:0] fo_s;
    logic              co_s;
    logic              dc_s;
    logic              z_s;
    logic [DATA_W:0]   sum_s;
    logic [4:0]        nib_s;
    logic [DATA_W-1:0] mask_s;

    // Result and flag computation from CB/B/FI/CI and the current W
    always_comb begin
        fo_s   = 8'h00;
        co_s   = bus.CI;
        dc_s   = 1'b0;
        z_s    = 1'b0;
        sum_s  = 9'h000;
        nib_s  = 5'h00;
        mask_s = 8'h01 << bus.B;
        if (bus.CB[4] == 1'b0) begin
            case (bus.CB)
                OP_MOVW:   fo_s = w_q;
                OP_CLR:    fo_s = 8'h00;
                OP_SUBWF: begin
                    // Two's-complement subtract: carry out is the no-borrow flag
                    sum_s = {1'b0, bus.FI} + {1'b0, ~w_q} + 9'h001;
                    nib_s = {1'b0, bus.FI[3:0]} + {1'b0, ~w_q[3:0]} + 5'h01;
                    fo_s  = sum_s[7:0];
                    co_s  = sum_s[8];
                    dc_s  = nib_s[4];
                end
                OP_DECF, OP_DECFSZ: fo_s = bus.FI - 8'h01;
                OP_IORWF:  fo_s = bus.FI | w_q;
                OP_ANDWF:  fo_s = bus.FI & w_q;
                OP_XORWF:  fo_s = bus.FI ^ w_q;
                OP_ADDWF: begin
                    sum_s = {1'b0, bus.FI} + {1'b0, w_q};
                    nib_s = {1'b0, bus.FI[3:0]} + {1'b0, w_q[3:0]};
                    fo_s  = sum_s[7:0];
                    co_s  = sum_s[8];
                    dc_s  = nib_s[4];
                end
                OP_MOVF:   fo_s = bus.FI;
                OP_COMF:   fo_s = ~bus.FI;
                OP_INCF, OP_INCFSZ: fo_s = bus.FI + 8'h01;
                OP_RRF: begin
                    fo_s = {bus.CI, bus.FI[7:1]};
                    co_s = bus.FI[0];
                end
                OP_RLF: begin
                    fo_s = {bus.FI[6:0], bus.CI};
                    co_s = bus.FI[7];
                end
                OP_SWAPF:  fo_s = {bus.FI[3:0], bus.FI[7:4]};
                default:   fo_s = 8'h00;
            endcase
            z_s = is_zero(fo_s);
        end else begin
            case (bus.CB[3:2])
                BG_BCF: begin
                    fo_s = bus.FI & ~mask_s;
                    z_s  = is_zero(fo_s);
                end
                BG_BSF: begin
                    fo_s = bus.FI | mask_s;
                    z_s  = is_zero(fo_s);
                end
                BG_BTFSC, BG_BTFSS: begin
                    // Bit test: Z reports a clear bit so the core can skip on it
                    fo_s = bus.FI;
                    z_s  = ~bus.FI[bus.B];
                end
                default: begin
                    fo_s = bus.FI;
                    z_s  = is_zero(fo_s);
                end
            endcase
        end
    end

    // Next W value: write the current result when enabled, else hold
    always_comb begin
        if (bus.WE) begin
            w_d = fo_s;
        end else begin
            w_d = w_q;
        end
    end

    // W register with synchronous reset overriding any write
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_q <= 8'h00;
        end else begin
            w_q <= w_d;
        end
    end

    assign bus.FO = fo_s;
    assign bus.CO = co_s;
    assign bus.DC = dc_s;
    assign bus.Z  = z_s;

endmodule

// File: tb/tb_pic16_alu.sv
// Directed, table-driven bench for the PIC16 ALU.
module tb_pic16_alu;
    import pic16_alu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pic16_alu_if bus ();

    pic16_alu u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] cb;
        logic       we;
        logic [2:0] b;
        logic [7:0] fi;
        logic       ci;
        logic [7:0] fo;
        logic       co;
        logic       dc;
        logic       z;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] cb, input logic we, input logic [2:0] b,
                                input logic [7:0] fi, input logic ci, input logic [7:0] fo,
                                input logic co, input logic dc, input logic z);
        vec_t v;
        v.cb = cb; v.we = we; v.b = b; v.fi = fi; v.ci = ci;
        v.fo = fo; v.co = co; v.dc = dc; v.z = z;
        return v;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cb, input logic we, input logic [2:0] b,
                         input logic [7:0] fi, input logic ci);
        bus.CB = cb; bus.WE = we; bus.B = b; bus.FI = fi; bus.CI = ci;
    endtask

    // Apply inputs mid-cycle, compare before the edge, then let the edge commit W
    task automatic run_vec(input int idx, input vec_t v);
        drive(v.cb, v.we, v.b, v.fi, v.ci);
        #1;
        chk8($sformatf("v%0d_fo", idx), bus.FO, v.fo);
        chk1($sformatf("v%0d_co", idx), bus.CO, v.co);
        chk1($sformatf("v%0d_dc", idx), bus.DC, v.dc);
        chk1($sformatf("v%0d_z",  idx), bus.Z,  v.z);
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //                cb        we    b     fi     ci    fo     co    dc    z
        vecs.push_back(mk(OP_MOVW,  1'b0, 3'd0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1)); // after reset
        vecs.push_back(mk(IPSF,     1'b1, 3'd0, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0)); // W <= 0F
        vecs.push_back(mk(IADD,     1'b0, 3'd0, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(ISUB,     1'b0, 3'd0, 8'h0E, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(ISUB,     1'b0, 3'd0, 8'h1F, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(OP_RRF,   1'b0, 3'd0, 8'h81, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(OP_RLF,   1'b0, 3'd0, 8'h81, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(5'b10100, 1'b0, 3'd1, 8'hA5, 1'b0, 8'hA7, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(5'b10000, 1'b0, 3'd7, 8'hA5, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(5'b11000, 1'b0, 3'd1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(5'b11100, 1'b0, 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(5'b10011, 1'b0, 3'd0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1)); // CB[1:0] ignored
        vecs.push_back(mk(OP_DECFSZ,1'b0, 3'd0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_SWAPF, 1'b0, 3'd0, 8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_MOVW,  1'b0, 3'd0, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0)); // W held
        vecs.push_back(mk(OP_CLR,   1'b0, 3'd0, 8'h77, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(OP_INCF,  1'b0, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1)); // wrap up
        vecs.push_back(mk(OP_DECF,  1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0)); // wrap down
        vecs.push_back(mk(IOR,      1'b0, 3'd0, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(IAND,     1'b0, 3'd0, 8'h3C, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(IXOR,     1'b0, 3'd0, 8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_COMF,  1'b0, 3'd0, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(OP_INCFSZ,1'b0, 3'd0, 8'h7F, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(IADD,     1'b1, 3'd0, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0)); // W <= 10
        vecs.push_back(mk(OP_MOVW,  1'b0, 3'd0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));

        // Reset with a pending write must leave W cleared
        rst = 1'b1;
        drive(IPSF, 1'b1, 3'd0, 8'h99, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
        end

        // Reset between operations discards W even with WE high
        drive(IPSF, 1'b1, 3'd0, 8'hAA, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(OP_MOVW, 1'b0, 3'd0, 8'h00, 1'b0);
        #1;
        chk8("rst_mid_fo", bus.FO, 8'h00);
        chk1("rst_mid_z", bus.Z, 1'b1);

        // First edge after reset release resumes writes
        drive(IPSF, 1'b1, 3'd0, 8'h5A, 1'b0);
        @(posedge clk);
        #2;
        drive(OP_MOVW, 1'b0, 3'd0, 8'h00, 1'b0);
        #1;
        chk8("resume_fo", bus.FO, 8'h5A);

        // Back-to-back accumulate: each write uses the pre-edge W
        drive(IADD, 1'b1, 3'd0, 8'h01, 1'b0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        drive(OP_MOVW, 1'b0, 3'd0, 8'h00, 1'b0);
        #1;
        chk8("accum_fo", bus.FO, 8'h5C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
